// File: rtl/vadd_float_control_s_axi_pkg.sv
// Shared register offsets, CTRL bit positions and bus FSM state types for the
// vadd_float AXI4-Lite control slave.
package vadd_float_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_GIE      = 8'h04;
  localparam logic [7:0] ADDR_IER      = 8'h08;
  localparam logic [7:0] ADDR_ISR      = 8'h0C;
  localparam logic [7:0] ADDR_SCALAR00 = 8'h10;
  localparam logic [7:0] ADDR_PTR0_LO  = 8'h18;
  localparam logic [7:0] ADDR_PTR0_HI  = 8'h1C;

  localparam int CTRL_AP_START     = 0;
  localparam int CTRL_AP_DONE      = 1;
  localparam int CTRL_AP_IDLE      = 2;
  localparam int CTRL_AP_READY     = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {
    WRIDLE = 2'd0,
    WRDATA = 2'd1,
    WRRESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RDIDLE = 1'b0,
    RDDATA = 1'b1
  } rd_state_t;

  // Expands the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/vadd_float_control_s_axi_if.sv
// AXI4-Lite control bus between the host (master) and the vadd_float control
// register file (slave).
interface vadd_float_control_s_axi_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 12
);

  logic                          awvalid;
  logic                          awready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic                          wvalid;
  logic                          wready;
  logic [31:0]                   wdata;
  logic [3:0]                    wstrb;
  logic                          bvalid;
  logic                          bready;
  logic [1:0]                    bresp;
  logic                          arvalid;
  logic                          arready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic                          rvalid;
  logic                          rready;
  logic [31:0]                   rdata;
  logic [1:0]                    rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/vadd_float_control_s_axi.sv
// AXI4-Lite register file driving the vadd_float kernel's ap_ctrl_hs handshake,
// its scalar/pointer arguments and a level interrupt back to the host.
module vadd_float_control_s_axi
  import vadd_float_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  vadd_float_control_s_axi_if.slave  s_axi_control,
  output logic                       interrupt,
  output logic                       ap_start,
  input  logic                       ap_done,
  input  logic                       ap_idle,
  input  logic                       ap_ready,
  output logic [31:0]                scalar00,
  output logic [63:0]                axi00_ptr0
);

  wr_state_t                     wstate;
  rd_state_t                     rstate;
  logic [7:0]                    waddr;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          r_hs;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [31:0]                   rdata_next;
  logic                          rd_ctrl_q;
  logic                          auto_restart;
  logic                          done_status;
  logic                          gie;
  logic [1:0]                    ier;
  logic [1:0]                    isr;
  logic [31:0]                   wmask;
  logic                          wr_ctrl;
  logic                          wr_gie;
  logic                          wr_ier;
  logic                          wr_isr;
  logic                          wr_scalar;
  logic                          wr_ptr_lo;
  logic                          wr_ptr_hi;
  logic [2*C_S_AXI_ADDR_WIDTH-1:0] unused_addr_bits;

  // Only addr[7:0] is decoded; the upper address bits alias onto the map.
  assign unused_addr_bits = {s_axi_control.awaddr, s_axi_control.araddr};

  assign s_axi_control.awready = (wstate == WRIDLE);
  assign s_axi_control.wready  = (wstate == WRDATA);
  assign s_axi_control.bvalid  = (wstate == WRRESP);
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = (rstate == RDIDLE);
  assign s_axi_control.rvalid  = (rstate == RDDATA);
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = 2'b00;

  assign aw_hs = s_axi_control.awvalid & s_axi_control.awready;
  assign w_hs  = s_axi_control.wvalid  & s_axi_control.wready;
  assign ar_hs = s_axi_control.arvalid & s_axi_control.arready;
  assign r_hs  = s_axi_control.rvalid  & s_axi_control.rready;

  assign wmask     = strb_to_mask(s_axi_control.wstrb);
  assign wr_ctrl   = w_hs && (waddr == ADDR_CTRL) && s_axi_control.wstrb[0];
  assign wr_gie    = w_hs && (waddr == ADDR_GIE)  && s_axi_control.wstrb[0];
  assign wr_ier    = w_hs && (waddr == ADDR_IER)  && s_axi_control.wstrb[0];
  assign wr_isr    = w_hs && (waddr == ADDR_ISR)  && s_axi_control.wstrb[0];
  assign wr_scalar = w_hs && (waddr == ADDR_SCALAR00);
  assign wr_ptr_lo = w_hs && (waddr == ADDR_PTR0_LO);
  assign wr_ptr_hi = w_hs && (waddr == ADDR_PTR0_HI);

  // Write channel: one transaction at a time, W is only accepted after AW.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate <= WRIDLE;
      waddr  <= 8'h00;
    end else begin
      case (wstate)
        WRIDLE: if (s_axi_control.awvalid) wstate <= WRDATA;
        WRDATA: if (s_axi_control.wvalid)  wstate <= WRRESP;
        WRRESP: if (s_axi_control.bready)  wstate <= WRIDLE;
        default: wstate <= WRIDLE;
      endcase
      if (aw_hs) waddr <= s_axi_control.awaddr[7:0];
    end
  end

  always_comb begin
    rdata_next = 32'h0;
    case (s_axi_control.araddr[7:0])
      ADDR_CTRL: begin
        rdata_next[CTRL_AP_START]     = ap_start;
        rdata_next[CTRL_AP_DONE]      = done_status;
        rdata_next[CTRL_AP_IDLE]      = ap_idle;
        rdata_next[CTRL_AP_READY]     = ap_ready;
        rdata_next[CTRL_AUTO_RESTART] = auto_restart;
      end
      ADDR_GIE:      rdata_next[0]   = gie;
      ADDR_IER:      rdata_next[1:0] = ier;
      ADDR_ISR:      rdata_next[1:0] = isr;
      ADDR_SCALAR00: rdata_next      = scalar00;
      ADDR_PTR0_LO:  rdata_next      = axi00_ptr0[31:0];
      ADDR_PTR0_HI:  rdata_next      = axi00_ptr0[63:32];
      default:       rdata_next      = 32'h0;
    endcase
  end

  // Read channel: data is captured at AR time so a concurrent write is not seen.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rstate    <= RDIDLE;
      rdata_q   <= '0;
      rd_ctrl_q <= 1'b0;
    end else begin
      case (rstate)
        RDIDLE: if (ar_hs) begin
          rstate    <= RDDATA;
          rdata_q   <= rdata_next;
          rd_ctrl_q <= (s_axi_control.araddr[7:0] == ADDR_CTRL);
        end
        RDDATA: if (s_axi_control.rready) rstate <= RDIDLE;
        default: rstate <= RDIDLE;
      endcase
    end
  end

  // ap_ctrl_hs bookkeeping; hardware events take priority over host clears.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_status  <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
    end else begin
      if (wr_ctrl && s_axi_control.wdata[CTRL_AP_START])
        ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)
        ap_start <= 1'b0;

      if (wr_ctrl) auto_restart <= s_axi_control.wdata[CTRL_AUTO_RESTART];

      if (ap_done)
        done_status <= 1'b1;
      else if (r_hs && rd_ctrl_q)
        done_status <= 1'b0;

      if (wr_gie) gie <= s_axi_control.wdata[0];
      if (wr_ier) ier <= s_axi_control.wdata[1:0];

      if (ap_done && ier[0])
        isr[0] <= 1'b1;
      else if (wr_isr && s_axi_control.wdata[0])
        isr[0] <= ~isr[0];

      if (ap_ready && ier[1])
        isr[1] <= 1'b1;
      else if (wr_isr && s_axi_control.wdata[1])
        isr[1] <= ~isr[1];

      interrupt <= gie & (|isr);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      scalar00   <= 32'h0;
      axi00_ptr0 <= 64'h0;
    end else begin
      if (wr_scalar)
        scalar00 <= (scalar00 & ~wmask) | (s_axi_control.wdata & wmask);
      if (wr_ptr_lo)
        axi00_ptr0[31:0] <= (axi00_ptr0[31:0] & ~wmask) | (s_axi_control.wdata & wmask);
      if (wr_ptr_hi)
        axi00_ptr0[63:32] <= (axi00_ptr0[63:32] & ~wmask) | (s_axi_control.wdata & wmask);
    end
  end

endmodule

// File: tb/tb_vadd_float_control_s_axi.sv
// Directed bench for vadd_float_control_s_axi: a transaction-level register model
// is checked against the kernel-side outputs every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_vadd_float_control_s_axi;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        interrupt;
  logic        ap_start;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic        ap_ready = 1'b0;
  logic [31:0] scalar00;
  logic [63:0] axi00_ptr0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_scalar;
  logic [63:0] m_ptr;
  bit          m_start, m_auto, m_done, m_gie;
  logic [1:0]  m_ier, m_isr;
  bit          prev_irq;

  always #5 ap_clk = ~ap_clk;

  vadd_float_control_s_axi_if #(.C_S_AXI_ADDR_WIDTH(12)) ctrl_if ();

  vadd_float_control_s_axi #(
    .C_S_AXI_ADDR_WIDTH(12),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ap_clk       (ap_clk),
    .areset       (areset),
    .s_axi_control(ctrl_if),
    .interrupt    (interrupt),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .scalar00     (scalar00),
    .axi00_ptr0   (axi00_ptr0)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_scalar = 32'h0;
    m_ptr    = 64'h0;
    m_start  = 1'b0;
    m_auto   = 1'b0;
    m_done   = 1'b0;
    m_gie    = 1'b0;
    m_ier    = 2'b00;
    m_isr    = 2'b00;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a)
      8'h00: if (s[0]) begin
        if (d[0]) m_start = 1'b1;
        m_auto = d[7];
      end
      8'h04: if (s[0]) m_gie = d[0];
      8'h08: if (s[0]) m_ier = d[1:0];
      8'h0C: if (s[0]) m_isr = m_isr ^ d[1:0];
      8'h10: m_scalar = merge_bytes(m_scalar, d, s);
      8'h18: m_ptr[31:0] = merge_bytes(m_ptr[31:0], d, s);
      8'h1C: m_ptr[63:32] = merge_bytes(m_ptr[63:32], d, s);
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return {24'h0, m_auto, 3'b000, ap_ready, ap_idle, m_done, m_start};
      8'h04: return {31'h0, m_gie};
      8'h08: return {30'h0, m_ier};
      8'h0C: return {30'h0, m_isr};
      8'h10: return m_scalar;
      8'h18: return m_ptr[31:0];
      8'h1C: return m_ptr[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic pulse_done();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    m_done = 1'b1;
    if (m_ier[0]) m_isr[0] = 1'b1;
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    if (!m_auto) m_start = 1'b0;
    if (m_ier[1]) m_isr[1] = 1'b1;
  endtask

  // AW and W are offered together so an early W beat must be stalled by the slave.
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int bhold);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    ctrl_if.awaddr = addr; ctrl_if.awvalid = 1'b1;
    ctrl_if.wdata = data; ctrl_if.wstrb = strb; ctrl_if.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = ctrl_if.awvalid && ctrl_if.awready;
      w_hs  = ctrl_if.wvalid && ctrl_if.wready;
      tick();
      n++;
      if (aw_hs) begin ctrl_if.awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin ctrl_if.wvalid = 1'b0; w_done = 1; model_write(addr[7:0], data, strb); end
    end
    check_output("aw_w_handshake", aw_done && w_done, 1);
    for (int i = 0; i < bhold; i++) begin
      check_output("bvalid_hold", ctrl_if.bvalid, 1);
      check_output("awready_busy", ctrl_if.awready, 0);
      tick();
    end
    ctrl_if.bready = 1'b1;
    n = 0;
    while (!ctrl_if.bvalid && n < 20) begin tick(); n++; end
    check_output("bvalid", ctrl_if.bvalid, 1);
    check_output("bresp", ctrl_if.bresp, 2'b00);
    tick();
    ctrl_if.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int rhold, input bit done_at_r,
                          output logic [31:0] data);
    logic [31:0] exp;
    bit ar_hs, ar_done;
    int n;
    exp = 32'h0; ar_done = 0; n = 0;
    ctrl_if.araddr = addr; ctrl_if.arvalid = 1'b1;
    while (!ar_done && n < 20) begin
      ar_hs = ctrl_if.arready;
      if (ar_hs) exp = model_read(addr[7:0]);
      tick();
      n++;
      if (ar_hs) begin ctrl_if.arvalid = 1'b0; ar_done = 1; end
    end
    check_output("ar_handshake", ar_done, 1);
    for (int i = 0; i < rhold; i++) begin
      check_output("rvalid_hold", ctrl_if.rvalid, 1);
      check_output("rdata_hold", ctrl_if.rdata, exp);
      tick();
    end
    ctrl_if.rready = 1'b1;
    ap_done = done_at_r;
    n = 0;
    while (!ctrl_if.rvalid && n < 20) begin tick(); n++; end
    check_output("rvalid", ctrl_if.rvalid, 1);
    check_output("rdata", ctrl_if.rdata, exp);
    check_output("rresp", ctrl_if.rresp, 2'b00);
    data = ctrl_if.rdata;
    tick();
    ctrl_if.rready = 1'b0;
    ap_done = 1'b0;
    if (addr[7:0] == 8'h00) m_done = done_at_r;
    else if (done_at_r) m_done = 1'b1;
    if (done_at_r && m_ier[0]) m_isr[0] = 1'b1;
  endtask

  // Kernel-side outputs against the model; interrupt trails the model ISR by a cycle.
  always @(negedge ap_clk) begin
    if (areset) begin
      prev_irq = 1'b0;
    end else begin
      check_output("scalar00", scalar00, m_scalar);
      check_output("axi00_ptr0", axi00_ptr0, m_ptr);
      check_output("ap_start", ap_start, m_start);
      check_output("interrupt", interrupt, prev_irq);
      prev_irq = m_gie & (|m_isr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n;
    ctrl_if.awvalid = 0; ctrl_if.awaddr = '0; ctrl_if.wvalid = 0; ctrl_if.wdata = '0;
    ctrl_if.wstrb = '0; ctrl_if.bready = 0; ctrl_if.arvalid = 0; ctrl_if.araddr = '0;
    ctrl_if.rready = 0;
    model_reset();
    tick(); tick(); tick();
    check_output("rst_awready", ctrl_if.awready, 1);
    check_output("rst_arready", ctrl_if.arready, 1);
    check_output("rst_wready", ctrl_if.wready, 0);
    check_output("rst_bvalid", ctrl_if.bvalid, 0);
    check_output("rst_rvalid", ctrl_if.rvalid, 0);
    check_output("rst_ap_start", ap_start, 0);
    check_output("rst_interrupt", interrupt, 0);
    check_output("rst_scalar00", scalar00, 0);
    check_output("rst_ptr", axi00_ptr0, 0);
    areset = 1'b0;
    tick();

    axi_write(12'h010, 32'hDEADBEEF, 4'b0011, 0);
    axi_read(12'h010, 0, 0, rd);
    check_output("scalar_partial_rd", rd, 32'h0000BEEF);
    check_output("scalar_partial_out", scalar00, 32'h0000BEEF);

    axi_write(12'h018, 32'h00001000, 4'hF, 0);
    axi_write(12'h01C, 32'h00000002, 4'hF, 0);
    check_output("ptr_literal", axi00_ptr0, 64'h0000_0002_0000_1000);
    axi_write(12'h000, 32'h00000001, 4'hF, 0);
    check_output("ap_start_set", ap_start, 1);
    tick(); tick();
    check_output("ap_start_holds", ap_start, 1);
    pulse_ready();
    check_output("ap_start_cleared", ap_start, 0);

    pulse_done();
    axi_read(12'h000, 0, 0, rd);
    check_output("done_first_read", rd[1], 1);
    axi_read(12'h000, 0, 0, rd);
    check_output("done_cleared", rd[1], 0);
    pulse_done();
    axi_read(12'h000, 0, 1, rd);
    check_output("done_race_read", rd[1], 1);
    axi_read(12'h000, 0, 0, rd);
    check_output("done_set_wins", rd[1], 1);
    axi_read(12'h000, 0, 0, rd);
    check_output("done_race_cleared", rd[1], 0);

    axi_write(12'h004, 32'h1, 4'hF, 0);
    axi_write(12'h008, 32'h1, 4'hF, 0);
    pulse_done();
    check_output("irq_latency0", interrupt, 0);
    tick();
    check_output("irq_raised", interrupt, 1);
    axi_write(12'h00C, 32'h1, 4'hF, 0);
    tick();
    check_output("irq_cleared", interrupt, 0);
    axi_write(12'h008, 32'h0, 4'hF, 0);
    pulse_done();
    axi_read(12'h00C, 0, 0, rd);
    check_output("isr_masked", rd, 32'h0);

    ap_idle = 1'b0;
    axi_write(12'h000, 32'h00000081, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_ready();
      check_output("auto_restart_start", ap_start, 1);
      tick();
    end
    axi_read(12'h000, 0, 0, rd);
    check_output("ctrl_auto_rd", rd & 32'h85, 32'h81);
    axi_write(12'h000, 32'h00000000, 4'hF, 0);
    check_output("write0_keeps_start", ap_start, 1);
    pulse_ready();
    check_output("start_after_auto_off", ap_start, 0);
    ap_idle = 1'b1;

    axi_write(12'h01C, 32'hAABBCCDD, 4'b0100, 5);
    check_output("ptr_hi_byte2", axi00_ptr0, 64'h00BB_0002_0000_1000);
    axi_read(12'h018, 4, 0, rd);
    check_output("ptr_lo_rd", rd, 32'h00001000);

    fork
      axi_write(12'h010, 32'hCAFEF00D, 4'hF, 0);
      axi_read(12'h010, 0, 0, rd);
    join
    check_output("concurrent_pre_write", rd, 32'h0000BEEF);
    check_output("concurrent_write", scalar00, 32'hCAFEF00D);

    axi_write(12'h040, 32'hFFFFFFFF, 4'hF, 0);
    axi_read(12'h040, 0, 0, rd);
    check_output("unmapped_rd", rd, 32'h0);
    axi_read(12'h014, 0, 0, rd);
    check_output("gap_rd", rd, 32'h0);
    axi_read(12'h110, 0, 0, rd);
    check_output("alias_rd", rd, 32'hCAFEF00D);

    ctrl_if.awaddr = 12'h010; ctrl_if.awvalid = 1'b1;
    n = 0;
    while (!ctrl_if.awready && n < 20) begin tick(); n++; end
    tick();
    ctrl_if.awvalid = 1'b0;
    check_output("mid_wready", ctrl_if.wready, 1);
    areset = 1'b1;
    model_reset();
    tick(); tick();
    check_output("mid_rst_bvalid", ctrl_if.bvalid, 0);
    check_output("mid_rst_wready", ctrl_if.wready, 0);
    check_output("mid_rst_awready", ctrl_if.awready, 1);
    check_output("mid_rst_scalar", scalar00, 32'h0);
    areset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("no_stale_bvalid", ctrl_if.bvalid, 0);
      tick();
    end
    axi_read(12'h010, 0, 0, rd);
    check_output("post_rst_rd", rd, 32'h0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vadd_float_control_s_axi.md
Name: vadd_float_control_s_axi

Overview:
AXI4-Lite slave register file that sits directly upstream of the vadd_float kernel core.
- Host writes kernel arguments and the start bit; the block drives ap_start, scalar00 and axi00_ptr0 into the kernel.
- Kernel returns ap_done, ap_idle and ap_ready; the block records them as status bits and raises a level interrupt.
- Implements the ap_ctrl_hs protocol, including auto-restart.

Parameters:
C_S_AXI_ADDR_WIDTH, 12, byte address width of the control interface.
C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32, any other value is unsupported.

Ports:
ap_clk  in  1  clock
areset  in  1  reset, synchronous, active-high
s_axi_control_awvalid  in  1  write-address valid
s_axi_control_awready  out  1  write-address ready
s_axi_control_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_control_wvalid  in  1  write-data valid
s_axi_control_wready  out  1  write-data ready
s_axi_control_wdata  in  32  write data
s_axi_control_wstrb  in  4  byte strobes
s_axi_control_bvalid  out  1  write-response valid
s_axi_control_bready  in  1  write-response ready
s_axi_control_bresp  out  2  write response, always 2'b00
s_axi_control_arvalid  in  1  read-address valid
s_axi_control_arready  out  1  read-address ready
s_axi_control_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_control_rvalid  out  1  read-data valid
s_axi_control_rready  in  1  read-data ready
s_axi_control_rdata  out  32  read data
s_axi_control_rresp  out  2  read response, always 2'b00
interrupt  out  1  level interrupt to host
ap_start  out  1  start request to kernel
ap_done  in  1  kernel done pulse
ap_idle  in  1  kernel idle level
ap_ready  in  1  kernel ready pulse
scalar00  out  32  scalar argument
axi00_ptr0  out  64  buffer base address

Behaviour:
Register map; only addr[7:0] is decoded:
- 0x00 CTRL: bit0 ap_start (R/W), bit1 ap_done (R, clear-on-read), bit2 ap_idle (R, live), bit3 ap_ready (R, live), bit7 auto_restart (R/W).
- 0x04 GIE: bit0 global interrupt enable.
- 0x08 IER: bit0 done enable, bit1 ready enable.
- 0x0C ISR: bit0 done, bit1 ready; writing 1 toggles the bit.
- 0x10 scalar00.
- 0x18 axi00_ptr0[31:0].
- 0x1C axi00_ptr0[63:32].
- Any other address: reads return 0, writes are ignored and still get a B response.

Write FSM, states WRIDLE -> WRDATA -> WRRESP -> WRIDLE:
- awready=1 only in WRIDLE; awaddr is latched on the AW handshake.
- wready=1 only in WRDATA; the register is updated on the W handshake.
- bvalid=1 in WRRESP, held until bready.
- One transaction is in flight at a time. A W beat arriving before AW is stalled by wready=0.

Read FSM, states RDIDLE -> RDDATA -> RDIDLE:
- arready=1 only in RDIDLE.
- rdata is registered on the AR handshake, and rvalid is asserted the next cycle.
- rdata is held stable until rready.

Byte strobes:
- wstrb applies per byte to scalar00, ptr low and ptr high.
- Control bits are updated only when wstrb[0]=1.

ap_start bit:
- Set by a write to 0x00 with wdata[0]=1.
- Cleared on the cycle ap_ready=1 unless auto_restart=1.
- Writing 0 does not clear it.

ap_done status bit:
- Set on ap_done=1.
- Cleared on the R handshake of a 0x00 read.
- If a set and a clear occur in the same cycle, the set wins.

ISR bits:
- ISR[0] is set on ap_done & IER[0]; ISR[1] is set on ap_ready & IER[1].
- A hardware set and a write-1 toggle in the same cycle: the set wins.

interrupt = GIE & |ISR, registered with 1-cycle latency.

Reset values:
- All registers, ap_start, interrupt, bvalid and rvalid are 0.
- awready=1, arready=1, wready=0.
- Reset mid-transaction aborts it with no response issued.

Simultaneous operations:
- A read and a write in the same cycle are both served.
- A read returns the pre-write register value.

Decomposition:
- Package vadd_float_ctrl_pkg holds:
  - register offset constants (ADDR_CTRL, ADDR_GIE, ADDR_IER, ADDR_ISR, ADDR_SCALAR00, ADDR_PTR0_LO, ADDR_PTR0_HI);
  - CTRL bit-index constants;
  - enum types wr_state_t {WRIDLE, WRDATA, WRRESP} and rd_state_t {RDIDLE, RDDATA}.
- Single module, no sub-modules.

Test Plan:
- Write 0x10=0xDEADBEEF with wstrb=4'b0011, then read 0x10 -> scalar00=0x0000BEEF and rdata=0x0000BEEF, bresp=rresp=0.
- Write 0x18=0x1000, 0x1C=0x2; write 0x00=1; pulse ap_ready -> axi00_ptr0=0x0000_0002_0000_1000, ap_start high until the ap_ready cycle, then 0.
- Pulse ap_done -> read 0x00 returns bit1=1; a second read returns bit1=0. ap_done asserted in the cycle of the first read's R handshake -> bit1 stays 1.
- GIE=1, IER=1, pulse ap_done -> interrupt=1 one cycle later. Write ISR=1 -> interrupt=0. IER=0 with a done pulse -> ISR stays 0.
- auto_restart: write 0x00=0x81, pulse ap_ready three times -> ap_start stays 1 throughout. Write 0x00=0x00, then pulse ap_ready -> ap_start=0.
- Protocol stress: hold bready=0 for 5 cycles -> bvalid stays high and awready=0. Hold rready=0 -> rdata stays stable. Assert areset mid-write -> bvalid=0, registers reset.
